hssl_cfg_pkt_rx: RTL
====================

HSSL_CFG_PKT_RX -- requirements
Module: hssl_cfg_pkt_rx

Interface
REQ-001 SHALL have parameter RADDR_BITS, default 8, meaning width of register word address (section 4 bits, register 4 bits).
REQ-002 SHALL have parameter CFG_KEY_PFX, default 24'hfffffe, meaning key[31:RADDR_BITS] value identifying a config packet.
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk  input  1  clock; resetn  input  1  asynchronous active-low reset.
REQ-004 pkt_key_in  input  32  incoming packet key.
REQ-005 pkt_data_in  input  32  incoming payload.
REQ-006 pkt_pld_in  input  1  payload present.
REQ-007 pkt_vld_in  input  1  incoming packet valid.
REQ-008 pkt_rdy_out  output  1  block can accept a packet.
REQ-009 fwd_key_out / fwd_data_out / fwd_pld_out  output  32/32/1  forwarded non-config packet.
REQ-010 fwd_vld_out  output  1 / fwd_rdy_in  input  1  forward handshake.
REQ-011 prx_addr_out  output  RADDR_BITS  register word address to register bank.
REQ-012 prx_wdata_out  output  32  register write data.
REQ-013 prx_en_out  output  1  single-cycle register write strobe.
REQ-014 cfg_cnt_out / drop_cnt_out  output  1/1  single-cycle pulses: config write issued / malformed config packet dropped.
REQ-015 reply_key_in  input  32  remote reply routing key.
REQ-016 ack_key_out / ack_data_out  output  32/32; ack_vld_out  output  1; ack_rdy_in  input  1  write-acknowledge packet.

Function
REQ-017 SHALL hold one input buffer entry; a packet is accepted when pkt_vld_in && pkt_rdy_out at a rising clk edge.
REQ-018 pkt_rdy_out SHALL be 1 when the buffer is empty or is freed in the same cycle (no bubble between back-to-back packets).
REQ-019 Buffered packet SHALL be classified CFG (key prefix match, pld=1), BAD (prefix match, pld=0) or FWD (no match).
REQ-020 States SHALL be EMPTY and FULL; EMPTY->FULL on accept; FULL->EMPTY on free without accept; FULL->FULL on free with accept, or when not freed.
REQ-021 CFG: prx_en_out=1, prx_addr_out=key[RADDR_BITS-1:0], prx_wdata_out=data and cfg_cnt_out=1, all for exactly the cycle the entry is freed; packet accepted in cycle N gives prx_en_out in cycle N+1 when not stalled.
REQ-022 BAD: entry freed in first FULL cycle, drop_cnt_out=1, no write, no forward.
REQ-023 FWD: fwd_vld_out=1 with buffered key/data/pld while FULL; entry freed only on fwd_rdy_in=1; outputs SHALL stay stable while fwd_rdy_in=0.
REQ-024 prx_en_out, cfg_cnt_out, drop_cnt_out and fwd_vld_out SHALL be mutually exclusive in any cycle.
REQ-025 prx_addr_out/prx_wdata_out SHALL be 0 when prx_en_out=0.

Reset
REQ-026 On resetn=0 SHALL enter EMPTY; pkt_rdy_out=0 while in reset, 1 the cycle after release; all other outputs 0.
REQ-027 Reset mid-operation SHALL discard buffered packet and pending ack with no write strobe or pulse.

Configuration
REQ-028 Macro HSSL_CFG_ACK_EN SHALL enable acknowledge generation.
REQ-029 With HSSL_CFG_ACK_EN: each CFG write SHALL load a one-entry ack register (ack_key_out=reply_key_in | key[RADDR_BITS-1:0], ack_data_out=wdata) in the same cycle as prx_en_out; ack_vld_out=1 until ack_rdy_in=1.
REQ-030 With HSSL_CFG_ACK_EN: a CFG entry SHALL be freed only if the ack register is empty or drained that cycle; otherwise it stalls in FULL with no prx_en_out.
REQ-031 Without HSSL_CFG_ACK_EN: ack ports SHALL exist, ack_vld_out/ack_key_out/ack_data_out held 0, ack_rdy_in and reply_key_in ignored, CFG never stalls.

Verification
REQ-032 key=0xfffffe23, data=0x12345678, pld=1 -> next cycle prx_en_out=1, addr=0x23, wdata=0x12345678, cfg_cnt_out=1, one cycle only.
REQ-033 key=0x00000040, pld=1, fwd_rdy_in=0 for 3 cycles then 1 -> fwd_vld_out stable 4 cycles, pkt_rdy_out=0 during stall, no prx_en_out.
REQ-034 key=0xfffffe05, pld=0 -> drop_cnt_out=1 one cycle, no prx_en_out, no fwd_vld_out.
REQ-035 10 back-to-back CFG packets, pkt_vld_in constant 1 -> 10 consecutive prx_en_out cycles, pkt_rdy_out never 0.
REQ-036 HSSL_CFG_ACK_EN, reply_key_in=0xfffffd00, two CFG packets addr 0x01/0x02, ack_rdy_in=0 -> first ack key 0xfffffd01 held, second write stalls until ack_rdy_in=1.
REQ-037 resetn=0 with FWD packet buffered -> fwd_vld_out=0 immediately, no packet after release.

Source files
------------

// File: rtl/hssl_cfg_pkt_rx.sv
// -----------------------------------------------------------------------------
// hssl_cfg_pkt_rx
//
// Single-entry receive buffer that separates configuration packets from normal
// traffic. A buffered packet whose key prefix matches CFG_KEY_PFX is treated
// as a register write (payload present) or dropped as malformed (no payload).
// Any other packet is forwarded unchanged through a valid/ready handshake.
//
// Optional feature (macro HSSL_CFG_ACK_EN): every register write also loads
// a one-entry acknowledge register, which is presented on the ack_* port. A
// config packet is held until that register is empty or draining.
// With the macro undefined, the ack outputs are tied to 0 and ack_rdy_in and
// reply_key_in are ignored.
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   pkt_key_in/data_in/pld_in   incoming packet key, payload, payload-present
//   pkt_vld_in / pkt_rdy_out    incoming packet handshake
//   fwd_key/data/pld_out        forwarded non-config packet
//   fwd_vld_out / fwd_rdy_in    forward handshake
//   prx_addr_out/wdata_out      register word address / write data
//   prx_en_out                  single-cycle register write strobe
//   cfg_cnt_out, drop_cnt_out   pulses: write issued / malformed packet dropped
//   reply_key_in                routing key used for acknowledge packets
//   ack_key/data_out            acknowledge packet
//   ack_vld_out / ack_rdy_in    acknowledge handshake
// -----------------------------------------------------------------------------
module hssl_cfg_pkt_rx #(
    parameter int unsigned RADDR_BITS  = 8,
    parameter logic [31:0] CFG_KEY_PFX = 32'h00fffffe
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic [31:0]           pkt_key_in,
    input  logic [31:0]           pkt_data_in,
    input  logic                  pkt_pld_in,
    input  logic                  pkt_vld_in,
    output logic                  pkt_rdy_out,

    output logic [31:0]           fwd_key_out,
    output logic [31:0]           fwd_data_out,
    output logic                  fwd_pld_out,
    output logic                  fwd_vld_out,
    input  logic                  fwd_rdy_in,

    output logic [RADDR_BITS-1:0] prx_addr_out,
    output logic [31:0]           prx_wdata_out,
    output logic                  prx_en_out,

    output logic                  cfg_cnt_out,
    output logic                  drop_cnt_out,

    input  logic [31:0]           reply_key_in,
    output logic [31:0]           ack_key_out,
    output logic [31:0]           ack_data_out,
    output logic                  ack_vld_out,
    input  logic                  ack_rdy_in
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic        state;
    logic        rdy_en;
    logic [31:0] buf_key;
    logic [31:0] buf_data;
    logic        buf_pld;

    logic        pfx_match;
    logic        is_cfg;
    logic        is_bad;
    logic        is_fwd;
    logic        ack_free;
    logic        cfg_go;
    logic        freed;
    logic        accept;

    logic        ack_vld;
    logic [31:0] ack_key;
    logic [31:0] ack_data;

    // Classification of the buffered entry
    assign pfx_match = ((buf_key >> RADDR_BITS) == CFG_KEY_PFX);
    assign is_cfg    = (state == ST_FULL) &&  pfx_match &&  buf_pld;
    assign is_bad    = (state == ST_FULL) &&  pfx_match && !buf_pld;
    assign is_fwd    = (state == ST_FULL) && !pfx_match;

    assign cfg_go    = is_cfg && ack_free;
    assign freed     = cfg_go || is_bad || (is_fwd && fwd_rdy_in);

    // rdy_en keeps the input closed until the first edge after reset release.
    // Ready also covers the cycle the entry is freed, so back-to-back packets
    // flow without a bubble.
    assign pkt_rdy_out = rdy_en && ((state == ST_EMPTY) || freed);
    assign accept      = pkt_vld_in && pkt_rdy_out;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_EMPTY;
            rdy_en   <= 1'b0;
            buf_key  <= '0;
            buf_data <= '0;
            buf_pld  <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (accept) begin
                state    <= ST_FULL;
                buf_key  <= pkt_key_in;
                buf_data <= pkt_data_in;
                buf_pld  <= pkt_pld_in;
            end else if (freed) begin
                state    <= ST_EMPTY;
            end
        end
    end

    // Register write side: address/data forced to 0 outside the strobe
    assign prx_en_out    = cfg_go;
    assign prx_addr_out  = cfg_go ? buf_key[RADDR_BITS-1:0] : '0;
    assign prx_wdata_out = cfg_go ? buf_data : '0;
    assign cfg_cnt_out   = cfg_go;
    assign drop_cnt_out  = is_bad;

    // Forward side: data outputs are 0 when nothing is offered
    assign fwd_vld_out   = is_fwd;
    assign fwd_key_out   = is_fwd ? buf_key  : '0;
    assign fwd_data_out  = is_fwd ? buf_data : '0;
    assign fwd_pld_out   = is_fwd && buf_pld;

`ifdef HSSL_CFG_ACK_EN
    // A new write may overwrite the ack register only in a cycle where the
    // previous acknowledge is being taken, which ack_free guarantees.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ack_vld  <= 1'b0;
            ack_key  <= '0;
            ack_data <= '0;
        end else if (cfg_go) begin
            ack_vld  <= 1'b1;
            ack_key  <= reply_key_in | 32'(buf_key[RADDR_BITS-1:0]);
            ack_data <= buf_data;
        end else if (ack_rdy_in) begin
            ack_vld  <= 1'b0;
        end
    end

    assign ack_free = !ack_vld || ack_rdy_in;
`else
    logic unused_ack_inputs;

    assign ack_vld  = 1'b0;
    assign ack_key  = '0;
    assign ack_data = '0;
    assign ack_free = 1'b1;
    assign unused_ack_inputs = ack_rdy_in ^ (^reply_key_in);
`endif

    assign ack_vld_out  = ack_vld;
    assign ack_key_out  = ack_vld ? ack_key  : '0;
    assign ack_data_out = ack_vld ? ack_data : '0;

endmodule
